seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Time-multiplexed two-digit seven-segment driver, directly downstream of the microprocessor's 14-bit segment output. It takes the two packed 7-segment patterns, snapshots them once per refresh frame so the two digits never show a torn value, and drives a shared segment bus with per-digit anode enables. Blanking gaps between digits suppress ghosting. A one-cycle frame tick is provided for test and pacing.

## Interface
Parameters:
- DIGIT_CYCLES, default 50000: cycles each digit is lit per frame; must be ≥1.
- BLANK_CYCLES, default 1000: blank cycles before each digit; ≥0; 0 removes the blank phases entirely.
- SEG_ACTIVE_LOW, default 1: 1 drives lit segments as 0.
- AN_ACTIVE_LOW, default 1: 1 drives the enabled anode as 0.

Ports:
- clk  in  1  system clock, same clock as the microprocessor.
- rst  in  1  asynchronous, active-high reset.
- seg_in  in  14  packed patterns: [13:7] left digit (an[1]), [6:0] right digit (an[0]); bit=1 means segment lit; bit order passed through unchanged.
- seg_out  out  7  shared segment bus, polarity per SEG_ACTIVE_LOW.
- an  out  2  digit enables, at most one active, polarity per AN_ACTIVE_LOW.
- frame_tick  out  1  one-cycle pulse at each frame boundary.

## Operation
- FSM states: BLANK0 -> SHOW0 -> BLANK1 -> SHOW1 -> BLANK0 (loop). With BLANK_CYCLES=0: SHOW0 <-> SHOW1.
- One phase counter; it loads 0 on each state entry and the state advances on the edge where the counter reaches (phase length − 1).
- BLANK states: an all inactive, seg_out all unlit.
- SHOW0: an[0] active, seg_out = latched[6:0]. SHOW1: an[1] active, seg_out = latched[13:7].
- Snapshot: the 14-bit latch loads seg_in on the edge that enters SHOW0. The latched value is held through SHOW0, BLANK1 and SHOW1. Changes to seg_in at any other time have no visible effect until the next SHOW0 entry.
- frame_tick: high for the single cycle following the exit of SHOW1, i.e. the first cycle of BLANK0 (or of SHOW0 when BLANK_CYCLES=0). Never asserted for the first frame after reset.
- Polarity: seg_out = SEG_ACTIVE_LOW ? ~pattern : pattern. Unlit is 7'h7F when active-low and 7'h00 when active-high. The same rule applies to an.
- Reset value (async, immediate, no clock needed): state BLANK0, or SHOW0-pending when BLANK_CYCLES=0; counter 0; latch 0; an all inactive; seg_out all unlit; frame_tick 0.
- With BLANK_CYCLES=0, outputs stay off during reset. The first edge after reset release enters SHOW0 and snapshots seg_in.
- Reset asserted mid-frame: outputs go to reset values asynchronously and the frame restarts from BLANK0 on release. No partial frame_tick is produced.

## Timing
- All outputs are registered and change only on clk rising edges, or asynchronously on rst. They are decoded from next-state so they are aligned with the state register.
- Frame length = 2·(BLANK_CYCLES + DIGIT_CYCLES) cycles.
- Cycle numbering: cycle 1 is the first cycle after rst deasserts. BLANK0 occupies cycles 1..B. SHOW0 occupies B+1..B+D. BLANK1 occupies B+D+1..2B+D. SHOW1 occupies 2B+D+1..2B+2D.
- frame_tick is high in cycle 2B+2D+1.
- Snapshot-to-display latency: 0 cycles. The pattern sampled on the SHOW0-entry edge appears on seg_out in that same first SHOW0 cycle.
- The counter width is sized to hold max(DIGIT_CYCLES, BLANK_CYCLES) − 1. No wrap occurs within a phase.

## Test plan
All scenarios use DIGIT_CYCLES=4, BLANK_CYCLES=2 and active-low polarity unless stated otherwise.
- Reset: hold rst for 3 cycles with seg_in=14'h3FFF -> seg_out=7'h7F, an=2'b11, frame_tick=0 during reset and in cycles 1–2.
- Basic frame: seg_in={7'b0000110,7'b1011011} -> cycles 3–6 show seg_out=7'b0100100, an=2'b10; cycles 7–8 show 7'h7F/2'b11; cycles 9–12 show seg_out=7'b1111001, an=2'b01; frame_tick=1 only in cycle 13.
- Tear immunity: change seg_in to 14'h0000 in cycle 4 -> cycles 4–12 still show the old patterns; cycles 15–18 show seg_out=7'h7F, an=2'b10.
- Async reset mid-SHOW1: assert rst between edges in cycle 10 -> an=2'b11 and seg_out=7'h7F before the next edge; after release the frame restarts, SHOW0 occupies cycles 3–6, and there is no frame_tick until the full frame completes.
- Active-high polarity (SEG_ACTIVE_LOW=0, AN_ACTIVE_LOW=0), seg_in={7'h06,7'h5B} -> SHOW0 gives seg_out=7'h5B, an=2'b01; SHOW1 gives seg_out=7'h06, an=2'b10; blank phases give 7'h00/2'b00.
- No blanking (BLANK_CYCLES=0) -> cycles 1–4 are SHOW0 and cycles 5–8 are SHOW1; frame_tick=1 in cycle 9 together with SHOW0; an is never 2'b11 after cycle 1.

Source files
------------

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: two-digit multiplexed seven-segment driver with per-frame snapshot and blanking
module seg_scan_driver #(
  parameter int DIGIT_CYCLES   = 50000,
  parameter int BLANK_CYCLES   = 1000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] seg_in,
  output logic [6:0]  seg_out,
  output logic [1:0]  an,
  output logic        frame_tick
);
  localparam int MAXP = DIGIT_CYCLES > BLANK_CYCLES ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW = MAXP > 1 ? $clog2(MAXP) : 1;
  localparam logic [CW-1:0] DL = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BL = CW'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
  localparam logic [6:0] SEG_X = SEG_ACTIVE_LOW != 0 ? 7'h7F : 7'h00;
  localparam logic [1:0] AN_X = AN_ACTIVE_LOW != 0 ? 2'b11 : 2'b00;
  localparam bit HAS_BLANK = BLANK_CYCLES > 0;
  typedef enum logic [1:0] {BLANK0, SHOW0, BLANK1, SHOW1} state_t;
  localparam state_t START = HAS_BLANK ? BLANK0 : SHOW0;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [13:0] lat_q, lat_d;
  logic fresh_q, last;
  logic [1:0] sel;
  logic [6:0] pat;
  // Next state, snapshot and output decode; fresh_q makes the first edge after a blank-less reset count as SHOW0 entry
  always_comb begin
    last = (state_q == BLANK0 || state_q == BLANK1) ? cnt_q == BL : cnt_q == DL;
    state_d = state_q;
    if (last)
      state_d = state_q == BLANK0 ? SHOW0 :
                state_q == SHOW0  ? (HAS_BLANK ? BLANK1 : SHOW1) :
                state_q == BLANK1 ? SHOW1 : (HAS_BLANK ? BLANK0 : SHOW0);
    cnt_d = last ? '0 : cnt_q + CW'(1);
    lat_d = (state_d == SHOW0 && (state_q != SHOW0 || fresh_q)) ? seg_in : lat_q;
    sel = state_d == SHOW0 ? 2'b01 : state_d == SHOW1 ? 2'b10 : 2'b00;
    pat = sel[0] ? lat_d[6:0] : sel[1] ? lat_d[13:7] : 7'h00;
  end
  // State, phase counter, latch and registered outputs aligned with the state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= START;
      cnt_q      <= '0;
      lat_q      <= '0;
      fresh_q    <= 1'b1;
      seg_out    <= SEG_X;
      an         <= AN_X;
      frame_tick <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lat_q      <= lat_d;
      fresh_q    <= 1'b0;
      seg_out    <= pat ^ SEG_X;
      an         <= sel ^ AN_X;
      frame_tick <= state_q == SHOW1 && last;
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: randomized check of several driver configurations against a frame-position model
module tb_seg_scan_driver;
  localparam int BC[4] = '{2, 2, 0, 1};
  localparam int DC[4] = '{4, 4, 4, 1};
  localparam int SL[4] = '{1, 0, 1, 1};
  localparam int AL[4] = '{1, 0, 1, 0};
  logic clk, rst;
  logic [13:0] seg_in;
  logic [6:0] seg_o [4];
  logic [1:0] an_o [4];
  logic tk_o [4];
  logic [13:0] lat [4];
  int k, n_cmp, n_err;
  seg_scan_driver #(.DIGIT_CYCLES(4), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) u0 (
    .clk(clk), .rst(rst), .seg_in(seg_in), .seg_out(seg_o[0]), .an(an_o[0]), .frame_tick(tk_o[0]));
  seg_scan_driver #(.DIGIT_CYCLES(4), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) u1 (
    .clk(clk), .rst(rst), .seg_in(seg_in), .seg_out(seg_o[1]), .an(an_o[1]), .frame_tick(tk_o[1]));
  seg_scan_driver #(.DIGIT_CYCLES(4), .BLANK_CYCLES(0), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) u2 (
    .clk(clk), .rst(rst), .seg_in(seg_in), .seg_out(seg_o[2]), .an(an_o[2]), .frame_tick(tk_o[2]));
  seg_scan_driver #(.DIGIT_CYCLES(1), .BLANK_CYCLES(1), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(0)) u3 (
    .clk(clk), .rst(rst), .seg_in(seg_in), .seg_out(seg_o[3]), .an(an_o[3]), .frame_tick(tk_o[3]));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic void expv(input int i, input int c, output logic [6:0] s, output logic [1:0] a, output logic t);
    int f, pos;
    logic [6:0] p;
    logic [1:0] e;
    p = 7'h00;
    e = 2'b00;
    t = 1'b0;
    if (c > 0 && !(BC[i] == 0 && c == 1)) begin
      f = 2 * (BC[i] + DC[i]);
      pos = (c - 1) % f;
      if (pos >= BC[i] && pos < BC[i] + DC[i]) begin
        p = lat[i][6:0];
        e = 2'b01;
      end else if (pos >= 2 * BC[i] + DC[i]) begin
        p = lat[i][13:7];
        e = 2'b10;
      end
      t = c > 1 && pos == 0;
    end
    s = p ^ (SL[i] != 0 ? 7'h7F : 7'h00);
    a = e ^ (AL[i] != 0 ? 2'b11 : 2'b00);
  endfunction
  function automatic bit snap(input int i, input int c);
    int f;
    f = 2 * (BC[i] + DC[i]);
    return BC[i] > 0 ? (c % f == BC[i]) : (c == 1 || c % f == 0);
  endfunction
  task automatic cyc(input logic r, input logic [13:0] s);
    logic [6:0] es;
    logic [1:0] ea;
    logic et;
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 4; i++) if (snap(i, k)) lat[i] = seg_in;
      k++;
    end
    #1;
    if (r) begin
      rst = 1'b1;
      k = 0;
      for (int i = 0; i < 4; i++) lat[i] = '0;
    end else if (rst) begin
      rst = 1'b0;
      k = 1;
    end
    seg_in = s;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      expv(i, k, es, ea, et);
      check($sformatf("seg%0d@%0d", i, k), 16'(seg_o[i]), 16'(es));
      check($sformatf("an%0d@%0d", i, k), 16'(an_o[i]), 16'(ea));
      check($sformatf("tick%0d@%0d", i, k), 16'(tk_o[i]), 16'(et));
    end
  endtask
  initial begin
    n_cmp = 0;
    n_err = 0;
    k = 0;
    for (int i = 0; i < 4; i++) lat[i] = '0;
    rst = 1'b0;
    seg_in = 14'h3FFF;
    #2 rst = 1'b1;
    repeat (3) cyc(1'b1, 14'h3FFF);
    repeat (3) cyc(1'b0, {7'b0000110, 7'b1011011});
    repeat (17) cyc(1'b0, 14'h0000);
    cyc(1'b1, 14'h1234);
    repeat (9) cyc(1'b0, {7'h06, 7'h5B});
    repeat (2) cyc(1'b1, 14'h2AAA);
    repeat (30) cyc(1'b0, $urandom_range(0, 3) == 0 ? 14'($urandom) : seg_in);
    repeat (300) cyc($urandom_range(0, 60) == 0, $urandom_range(0, 3) == 0 ? 14'($urandom) : seg_in);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
